// File: rtl/pc_sequencer.sv
// Program-counter sequencer: next-PC selection, branch conditions,
// stall hold, halt/resume and trap entry/return with an EPC register.
module pc_sequencer #(
    parameter int unsigned      WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_PC    = 'h0,
    parameter logic [WIDTH-1:0] TRAP_PC     = 'h80,
    parameter bit               ALIGN_CHECK = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [2:0]       pc_sel,
    input  logic [2:0]       br_cond,
    input  logic             zero,
    input  logic             neg,
    input  logic [WIDTH-1:0] branch_target,
    input  logic [WIDTH-1:0] jump_target,
    input  logic [WIDTH-1:0] jr_target,
    input  logic             stall,
    input  logic             halt,
    input  logic             resume,
    input  logic             trap_req,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] epc,
    output logic [1:0]       cause,
    output logic             halted,
    output logic             taken
);

    typedef enum logic {
        ST_RUN,
        ST_HALTED
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] epc_q;
    logic [1:0]       cause_q;
    logic             halted_q;

    logic [WIDTH-1:0] pc_d;
    logic             cond;
    logic             redirect;
    logic             misaligned;

    assign pc_plus4 = pc_q + WIDTH'(4);

    always_comb begin
        cond = 1'b0;
        case (br_cond)
            3'b000:  cond = zero;
            3'b001:  cond = !zero;
            3'b010:  cond = neg;
            3'b011:  cond = !neg;
            3'b100:  cond = neg | zero;
            3'b101:  cond = !neg & !zero;
            3'b110:  cond = 1'b1;
            default: cond = 1'b0;
        endcase
    end

    // Only redirects sourced from decode/ALU or EPC are alignment checked.
    always_comb begin
        pc_d     = pc_plus4;
        redirect = 1'b0;
        case (pc_sel)
            3'b001: begin
                if (cond) begin
                    pc_d     = branch_target;
                    redirect = 1'b1;
                end
            end
            3'b010: begin
                pc_d     = jump_target;
                redirect = 1'b1;
            end
            3'b011: begin
                pc_d     = jr_target;
                redirect = 1'b1;
            end
            3'b100: begin
                pc_d     = epc_q;
                redirect = 1'b1;
            end
            3'b101:  pc_d = RESET_PC;
            default: pc_d = pc_plus4;
        endcase
    end

    assign taken      = (pc_sel == 3'b001) && cond;
    assign misaligned = ALIGN_CHECK && redirect && (pc_d[1:0] != 2'b00);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_RUN;
            pc_q     <= RESET_PC;
            epc_q    <= '0;
            cause_q  <= 2'b00;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (trap_req) begin
                        epc_q   <= pc_q;
                        cause_q <= 2'b01;
                        pc_q    <= TRAP_PC;
                    end else if (misaligned) begin
                        epc_q   <= pc_q;
                        cause_q <= 2'b10;
                        pc_q    <= TRAP_PC;
                    end else if (halt) begin
                        state_q  <= ST_HALTED;
                        halted_q <= 1'b1;
                    end else if (!stall) begin
                        pc_q <= pc_d;
                    end
                end
                ST_HALTED: begin
                    if (trap_req) begin
                        epc_q    <= pc_q;
                        cause_q  <= 2'b01;
                        pc_q     <= TRAP_PC;
                        state_q  <= ST_RUN;
                        halted_q <= 1'b0;
                    end else if (resume) begin
                        state_q  <= ST_RUN;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= ST_RUN;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign pc     = pc_q;
    assign epc    = epc_q;
    assign cause  = cause_q;
    assign halted = halted_q;

endmodule
